uart_tx_ctrl: RTL

Controller for the core's UART write channel. It replaces the always-ready stub with real flow control. Bytes from the core's `{valid, data}` write interface are buffered in a small FIFO and serialized 8N1 onto a TX line at a fixed bit period. `wr_ready` is driven back to the core so the core stalls on a full FIFO. The block sits between the core's `ext_uart_write` port and the board or simulation UART pin.

---
 rtl/uart_tx_ctrl_if.sv | 30 +++
 rtl/uart_tx_ctrl.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
// Byte write channel between the core and the UART transmit controller.
//
//   wr_valid  core -> ctrl   core offers a byte
//   wr_data   core -> ctrl   byte offered (8 bits)
//   wr_ready  ctrl -> core   controller FIFO can accept; a transfer happens on
//                            any cycle with wr_valid && wr_ready
//
// Modports:
//   master : the core side (drives valid/data, observes ready)
//   slave  : the controller side (observes valid/data, drives ready)
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// Flow-controlled UART transmitter for the core's write channel. Bytes taken
// from the write interface are queued in a small FIFO and sent 8N1
// (start bit, 8 data bits LSB first, one stop bit) at CLKS_PER_BIT clocks
// per bit. Back-to-back frames are sent with no idle gap while the FIFO
// holds data.
//
// Parameters:
//   CLKS_PER_BIT  clocks per serial bit (>= 2)
//   DEPTH         FIFO entries (power of two, >= 2)
//
// Ports:
//   CLK    input   clock, all logic on the rising edge
//   RST    input   synchronous reset, active high
//   wr     slave   write channel (wr_valid, wr_data, wr_ready)
//   tx     output  serial line, idles high, registered
//   busy   output  high while a frame is on the line
//   level  output  current FIFO occupancy
// ---------------------------------------------------------------------------
module uart_tx_ctrl #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DEPTH        = 4
) (
    input  logic                       CLK,
    input  logic                       RST,
    uart_tx_ctrl_if.slave              wr,
    output logic                       tx,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // FIFO storage and bookkeeping
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    // Serializer state
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_clk_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_tx;
    logic             r_busy;

    logic w_ready;
    logic w_push;
    logic w_pop;
    logic w_bit_end;
    logic w_not_empty;

    // Ready comes only from the registered level, so a pop in the same
    // cycle cannot open the door for a push into a full FIFO.
    assign w_ready     = (r_level != LVL_FULL);
    assign w_push      = wr.wr_valid && w_ready;
    assign w_not_empty = (r_level != '0);
    assign w_bit_end   = (r_clk_cnt == CNT_LAST);

    // A byte leaves the FIFO only when the serializer loads it: from IDLE,
    // or on the final stop-bit cycle to chain the next frame directly.
    assign w_pop = w_not_empty &&
                   ((r_state == S_IDLE) || (r_state == S_STOP && w_bit_end));

    assign wr.wr_ready = w_ready;
    assign tx          = r_tx;
    assign busy        = r_busy;
    assign level       = r_level;

    // FIFO storage carries no reset; stale entries are unreachable once the
    // pointers are cleared.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr.wr_data;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // tx/busy are updated together with the state so they only move on
    // state or bit boundaries.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= S_IDLE;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (w_pop) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_START;
                        r_tx      <= 1'b0;
                        r_busy    <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_state   <= S_DATA;
                        r_tx      <= r_shift[0];
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            r_shift   <= {1'b0, r_shift[7:1]};
                            // next bit is the one about to land in shift[0]
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (w_pop) begin
                            r_shift   <= r_mem[r_rd_ptr];
                            r_bit_idx <= '0;
                            r_state   <= S_START;
                            r_tx      <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef SIMULATION
    always_ff @(posedge CLK) begin
        if (!RST) begin
            assert (!(w_push && r_level == LVL_FULL))
                else $error("uart_tx_ctrl: push while FIFO full");
            assert (!(w_pop && r_level == '0))
                else $error("uart_tx_ctrl: pop while FIFO empty");
        end
    end
`endif

endmodule
